// File: rtl/complex_tile_pingpong_buffer_pkg.sv
// Shared types and helpers for the complex tile ping-pong buffer.
//
// Contents:
//   TILE_DEFAULT, DATA_WIDTH_DEFAULT, DEPTH_DEFAULT - default build parameters
//   complex_t    - one complex sample, {real, imag}, real in the upper half
//   tile_t       - TILE x TILE complex samples; element [r][c] sits at flat
//                  index r*TILE+c counted from the LSB
//   bank_state_e - lifecycle of one storage bank
//   holds_data / accepts_write - bank state classification helpers
//
// Packages cannot take parameters, so complex_t and tile_t describe the
// default configuration. The modules carry their own parameters and slice
// the flat tile vector with the same element layout.
package complex_tile_pingpong_buffer_pkg;

  localparam int TILE_DEFAULT       = 4;
  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int DEPTH_DEFAULT      = 64;

  typedef struct packed {
    logic [DATA_WIDTH_DEFAULT-1:0] re;
    logic [DATA_WIDTH_DEFAULT-1:0] im;
  } complex_t;

  typedef complex_t [TILE_DEFAULT-1:0][TILE_DEFAULT-1:0] tile_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_e;

  // A bank the reader may pull tiles from.
  function automatic logic holds_data(input bank_state_e s);
    return (s == FULL) || (s == DRAINING);
  endfunction

  // A bank the writer may push tiles into.
  function automatic logic accepts_write(input bank_state_e s);
    return (s == EMPTY) || (s == FILLING);
  endfunction

endpackage

// File: rtl/complex_tile_pingpong_buffer_ram.sv
// Simple dual-port tile RAM with a registered read port.
//
// Ports:
//   clk           - clock
//   we            - write enable
//   write_address - write tile address, {bank, ptr}
//   data_in       - tile to store
//   re            - read enable; data_out keeps its value while low
//   read_address  - read tile address, {bank, ptr}
//   data_out      - tile read on the previous enabled cycle
//
// The buffer never reads and writes the same bank in one cycle, so no
// read-during-write behaviour needs to be defined.
module complex_tile_ram #(
  parameter int WIDTH      = 256,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [WIDTH-1:0]      data_in,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [WIDTH-1:0]      data_out
);

  // Sized to the full {bank, ptr} space, which is 2*DEPTH for a
  // power-of-two bank depth.
  logic [WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[write_address] <= data_in;
    end
    if (re) begin
      data_out <= mem[read_address];
    end
  end

endmodule

// File: rtl/complex_tile_pingpong_buffer.sv
// Double-buffered store for TILE x TILE complex tiles between a 2D FFT stage
// and its consumers. The writer fills one bank while the reader drains the
// other; each bank can optionally be read out transposed.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   wr_valid     - write tile valid
//   wr_ready     - buffer can accept a write tile
//   wr_last      - accepted tile closes the current bank early
//   wr_data      - tile in, element [r][c] at index r*TILE+c, {real, imag}
//   rd_transpose - readout mode latched when the next bank starts draining
//   rd_valid     - rd_data holds a tile
//   rd_ready     - consumer accepts the tile
//   rd_data      - tile out
//   rd_last      - rd_data is the final tile of its bank
//   bank_full    - per-bank FULL-or-DRAINING status
module complex_tile_pingpong_buffer
  import complex_tile_pingpong_buffer_pkg::*;
#(
  parameter int TILE       = TILE_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = DEPTH_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic                               wr_last,
  input  logic [TILE*TILE*2*DATA_WIDTH-1:0]  wr_data,
  input  logic                               rd_transpose,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [TILE*TILE*2*DATA_WIDTH-1:0]  rd_data,
  output logic                               rd_last,
  output logic [1:0]                         bank_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DATA_WIDTH;
  localparam int TW = TILE * TILE * EW;
  localparam logic [CW-1:0] PTR_ONE  = CW'(1);
  localparam logic [CW-1:0] LAST_PTR = CW'(DEPTH - 1);

  bank_state_e     bank_state [2];
  bank_state_e     bank_state_next [2];
  logic [CW-1:0]   count [2];
  logic [CW-1:0]   count_next [2];
  logic            mode [2];
  logic            mode_next [2];
  logic            wbank, wbank_next;
  logic            rbank, rbank_next;
  logic [CW-1:0]   wptr, wptr_next;
  logic [CW-1:0]   rptr, rptr_next;
  logic            rd_valid_q, rd_valid_next;
  logic            rd_last_q, rd_last_next;
  logic            out_transpose, out_transpose_next;
  logic            data_zero, data_zero_next;
  logic            tile_mode;
  logic            wr_accept, wr_close, rd_issue, rd_final;
  logic [TW-1:0]   ram_out;
  logic [TW-1:0]   rd_tile;

  assign wr_ready  = !reset && accepts_write(bank_state[wbank]);
  assign wr_accept = wr_valid && wr_ready;
  assign wr_close  = wr_accept && ((wptr == LAST_PTR) || wr_last);

  // The output register may be refilled when it is empty or being consumed.
  assign rd_issue  = holds_data(bank_state[rbank]) && (rptr < count[rbank]) &&
                     (!rd_valid_q || rd_ready);
  assign rd_final  = rd_issue && (rptr == count[rbank] - PTR_ONE);

  // Bank state machines, pointers and output-register bookkeeping. The
  // writer and reader never own the same bank, so their updates below
  // always touch different entries of the per-bank arrays.
  always_comb begin
    bank_state_next    = bank_state;
    count_next         = count;
    mode_next          = mode;
    wbank_next         = wbank;
    wptr_next          = wptr;
    rbank_next         = rbank;
    rptr_next          = rptr;
    rd_valid_next      = rd_valid_q;
    rd_last_next       = rd_last_q;
    out_transpose_next = out_transpose;
    data_zero_next     = data_zero;
    tile_mode          = mode[rbank];

    if (wr_accept) begin
      if (wr_close) begin
        bank_state_next[wbank] = FULL;
        count_next[wbank]      = wptr + PTR_ONE;
        wptr_next              = '0;
        wbank_next             = ~wbank;
      end else begin
        bank_state_next[wbank] = FILLING;
        wptr_next              = wptr + PTR_ONE;
      end
    end

    if (rd_issue) begin
      // The readout mode is captured on the first read of a bank and then
      // held, so toggling rd_transpose mid-drain only affects the next bank.
      if (bank_state[rbank] == FULL) begin
        tile_mode = rd_transpose;
      end
      mode_next[rbank]   = tile_mode;
      out_transpose_next = tile_mode;
      rd_valid_next      = 1'b1;
      rd_last_next       = rd_final;
      data_zero_next     = 1'b0;
      if (rd_final) begin
        bank_state_next[rbank] = EMPTY;
        rptr_next              = '0;
        rbank_next             = ~rbank;
      end else begin
        bank_state_next[rbank] = DRAINING;
        rptr_next              = rptr + PTR_ONE;
      end
    end else if (rd_ready) begin
      rd_valid_next = 1'b0;
      rd_last_next  = 1'b0;
    end
  end

  // State register; reset discards everything stored or in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        bank_state[i] <= EMPTY;
        count[i]      <= '0;
        mode[i]       <= 1'b0;
      end
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      rd_valid_q    <= 1'b0;
      rd_last_q     <= 1'b0;
      out_transpose <= 1'b0;
      data_zero     <= 1'b1;
    end else begin
      bank_state    <= bank_state_next;
      count         <= count_next;
      mode          <= mode_next;
      wbank         <= wbank_next;
      rbank         <= rbank_next;
      wptr          <= wptr_next;
      rptr          <= rptr_next;
      rd_valid_q    <= rd_valid_next;
      rd_last_q     <= rd_last_next;
      out_transpose <= out_transpose_next;
      data_zero     <= data_zero_next;
    end
  end

  complex_tile_ram #(
    .WIDTH      (TW),
    .ADDR_WIDTH (CW)
  ) u_ram (
    .clk           (clk),
    .we            (wr_accept),
    .write_address ({wbank, wptr[AW-1:0]}),
    .data_in       (wr_data),
    .re            (rd_issue),
    .read_address  ({rbank, rptr[AW-1:0]}),
    .data_out      (ram_out)
  );

  // Transpose is a pure element permutation on the RAM output register,
  // selected by the mode that travelled with the tile, so it adds no latency.
  always_comb begin
    rd_tile = '0;
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        if (out_transpose) begin
          rd_tile[(r*TILE+c)*EW +: EW] = ram_out[(c*TILE+r)*EW +: EW];
        end else begin
          rd_tile[(r*TILE+c)*EW +: EW] = ram_out[(r*TILE+c)*EW +: EW];
        end
      end
    end
  end

  // The RAM output register has no reset, so rd_data is forced to zero
  // until the first tile after reset has actually been read.
  assign rd_data      = (reset || data_zero) ? '0 : rd_tile;
  assign rd_valid     = rd_valid_q && !reset;
  assign rd_last      = rd_last_q && rd_valid_q && !reset;
  assign bank_full[0] = !reset && holds_data(bank_state[0]);
  assign bank_full[1] = !reset && holds_data(bank_state[1]);

endmodule

// File: doc/complex_tile_pingpong_buffer.md
Name: complex_tile_pingpong_buffer

Overview:
- Double-buffered (ping-pong) store for TILE x TILE complex tiles between a 2D FFT stage and downstream consumers.
- Writer fills one bank while the reader drains the other. Both sides use valid/ready handshakes.
- Parametrised in tile size, component width and bank depth.
- Optional per-bank transposed readout supports row/column passes of the 2D FFT.

Parameters:
- TILE, 4, tile edge length; a tile holds TILE*TILE complex elements.
- DATA_WIDTH, 32, width of each real and each imaginary component.
- DEPTH, 64, tiles per bank; must be at least 2.
- AW, $clog2(DEPTH), tile address width (derived, not overridden).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high reset.
- wr_valid, in, 1, write tile valid.
- wr_ready, out, 1, buffer can accept a write tile.
- wr_last, in, 1, this tile closes the current bank early (partial bank).
- wr_data, in, TILE*TILE*2*DATA_WIDTH, element [r][c] at index r*TILE+c; each element is {real, imag} with real in the upper half.
- rd_transpose, in, 1, readout mode for the next bank to start draining.
- rd_valid, out, 1, rd_data holds a tile.
- rd_ready, in, 1, consumer accepts the tile.
- rd_data, out, same width as wr_data, output tile.
- rd_last, out, 1, rd_data is the final tile of its bank.
- bank_full, out, 2, per-bank FULL-or-DRAINING flags, for status.

Behaviour:
- Reset values:
  - While reset is high: rd_valid=0, rd_data=0, rd_last=0, bank_full=0, wr_ready=0.
  - Both banks EMPTY; wbank=0, rbank=0; all counters 0.
  - Reset mid-operation discards all stored and in-flight data.
- Per-bank state machine: EMPTY -> FILLING on the first accepted write; FILLING -> FULL; FULL -> DRAINING on the first read issue; DRAINING -> EMPTY.
- Write side:
  - wr_ready = !reset && bank[wbank] in {EMPTY, FILLING}.
  - On wr_valid && wr_ready, the tile is written at wptr and wptr increments.
  - The bank moves FILLING -> FULL when wptr reaches DEPTH-1 or wr_last is set on the accepted tile.
  - On that transition: count[wbank] is latched to wptr+1, wptr resets to 0 and wbank toggles in the same cycle.
  - If the other bank is still FULL or DRAINING, wr_ready is 0 from the next cycle until that bank returns to EMPTY.
- Read issue:
  - A read is issued when bank[rbank] is FULL or DRAINING, rptr < count, and (!rd_valid || rd_ready).
  - rd_transpose is sampled on the FULL -> DRAINING transition and held for the whole bank.
- Read timing:
  - Memory read latency is 1 cycle. Issue at cycle N gives rd_valid=1 with data at cycle N+1.
  - rd_data holds stable while rd_valid && !rd_ready.
  - Full throughput is one tile per cycle when rd_ready is held at 1.
- Transpose: when enabled, output element [r][c] = stored element [c][r]. This is a combinational mux after the memory output register; it adds no latency.
- Bank drain:
  - rd_last is asserted with the tile issued at rptr = count-1.
  - When that tile is issued: the bank goes to EMPTY, rptr resets to 0 and rbank toggles.
  - The writer may therefore refill that bank from the next cycle.
- Simultaneous events:
  - A write into one bank and a read from the other in the same cycle are both legal.
  - The writer closing bank A in the same cycle the reader releases bank B produces no stall.
- Edge cases:
  - wr_last on the first tile gives count=1.
  - wr_last when wptr=DEPTH-1 is identical to a natural full.
  - wr_valid while wr_ready=0 is ignored; the source must hold the tile.
- Widths: counters are AW+1 bits; count ranges 1..DEPTH. No arithmetic on data.

Decomposition:
- Shared package holds:
  - complex_t parametrised by DATA_WIDTH.
  - tile_t, a packed array [TILE][TILE] of complex_t.
  - The bank_state_e enum {EMPTY, FILLING, FULL, DRAINING}.
- One sub-module: complex_tile_ram, a simple dual-port RAM with a registered read.
  - Depth 2*DEPTH; address = {bank, ptr}.
  - Ports: we, write_address, data_in, re, read_address, data_out.
  - data_out holds its value when re=0.

Test Plan:
- Fill and drain: DEPTH=4, write 4 tiles with element value = tile index, rd_ready=1 -> rd_valid rises 2 cycles after the bank closes; tiles 0..3 come out in order; rd_last on tile 3.
- Ping-pong: stream 3*DEPTH tiles with rd_ready=1 -> wr_ready never drops after the first bank; output equals input order.
- Backpressure: both banks full, rd_ready=0 for 10 cycles -> wr_ready=0 and rd_data stable; releasing rd_ready drains one tile per cycle.
- Partial bank: wr_last on the 2nd tile -> only 2 tiles are read, rd_last on the 2nd, and the writer moves to the other bank immediately.
- Transpose: store a tile with [r][c] = r*4+c and rd_transpose=1 -> output [r][c] = c*4+r; toggling rd_transpose mid-drain has no effect until the next bank.
- Reset mid-drain: assert reset for 1 cycle while rd_valid=1 -> rd_valid=0, bank_full=0; the next written tile is the first tile read.
